// File: rtl/xilly_stream_fifo.sv
// xilly_stream_fifo
//   Single-clock stream FIFO between a host-to-FPGA write stream and an
//   FPGA-to-host read stream. Reads use standard (non-FWFT) timing: the popped
//   word appears on user_r_data one cycle after the accepted rden. An optional
//   frame mode ends each read session with EOF after FRAME_WORDS pops.
//
// Ports
//   bus_clk      : clock, all logic on the rising edge
//   reset        : synchronous active-high reset
//   user_w_wren  : write request          user_w_data : write data
//   user_w_full  : storage full           user_w_open : write file open
//   user_r_rden  : read request           user_r_data : registered read data
//   user_r_empty : nothing to read        user_r_eof  : end of file (frame mode)
//   user_r_open  : read file open
//   level        : words currently stored overflow    : sticky dropped-write flag
module xilly_stream_fifo #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_LOG2  = 9,
  parameter int FRAME_WORDS = 0
) (
  input  logic                  bus_clk,
  input  logic                  reset,
  input  logic                  user_w_wren,
  input  logic [WIDTH-1:0]      user_w_data,
  output logic                  user_w_full,
  input  logic                  user_w_open,
  input  logic                  user_r_rden,
  output logic [WIDTH-1:0]      user_r_data,
  output logic                  user_r_empty,
  output logic                  user_r_eof,
  input  logic                  user_r_open,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_overflow;
  logic [WIDTH-1:0]      r_rd_data;

  logic w_flush;
  logic w_full;
  logic w_store_empty;
  logic w_r_empty;
  logic w_frame_done;
  logic w_wr_ok;
  logic w_rd_ok;

  // Closing both device files is treated like a reset: the session is over.
  assign w_flush       = reset | (~user_w_open & ~user_r_open);
  assign w_full        = (r_level == FULL_LEVEL);
  assign w_store_empty = (r_level == '0);
  assign w_r_empty     = w_store_empty | w_frame_done;

  assign w_rd_ok = ~w_flush & user_r_rden & ~w_r_empty;
  // A write while full still goes through when a pop frees a slot on the same
  // edge; the RAM is read-first, so the slot's old word is read out before the
  // new word lands in it.
  assign w_wr_ok = ~w_flush & user_w_wren & (~w_full | w_rd_ok);

  // Storage: no reset so it maps onto block RAM.
  always_ff @(posedge bus_clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= user_w_data;
    end
  end

  // Registered read port (RAM output register with synchronous clear).
  always_ff @(posedge bus_clk) begin
    if (w_flush) begin
      r_rd_data <= '0;
    end else if (w_rd_ok) begin
      r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  // Pointers, fill level and sticky overflow.
  always_ff @(posedge bus_clk) begin
    if (w_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // Without flush, a refused write can only mean full with no pop.
      if (user_w_wren && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  generate
    if (FRAME_WORDS > 0) begin : g_frame
      localparam int CNT_W = DEPTH_LOG2 + 13;
      localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_WORDS - 1);

      logic [CNT_W-1:0] r_frame_cnt;
      logic             r_frame_done;

      // Session state lives only while the read file is open; words written
      // after EOF stay in storage for the next session.
      always_ff @(posedge bus_clk) begin
        if (w_flush || !user_r_open) begin
          r_frame_cnt  <= '0;
          r_frame_done <= 1'b0;
        end else if (w_rd_ok) begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
          if (r_frame_cnt == FRAME_LAST) begin
            r_frame_done <= 1'b1;
          end
        end
      end

      assign w_frame_done = r_frame_done;
    end else begin : g_no_frame
      assign w_frame_done = 1'b0;
    end
  endgenerate

  assign user_w_full  = w_full;
  assign user_r_empty = w_r_empty;
  assign user_r_eof   = w_frame_done;
  assign user_r_data  = r_rd_data;
  assign level        = r_level;
  assign overflow     = r_overflow;

endmodule
